fifo_ctrl_dp: RTL and testbench

- Synchronous FIFO controller placed directly upstream of the 64x8 true dual-port RAM. It converts push/pop requests into RAM port commands.
- RAM port 1 is used as the write port; RAM port 2 is used read-only.
- Manages the pointers, occupancy and flags, and qualifies the RAM's registered read data with a valid strobe.
- Pairs with the RAM to form the team's standard buffering FIFO for byte streams.

---
 rtl/fifo_defs.sv | 18 +
 rtl/fifo_ptr.sv | 25 ++
 rtl/fifo_ctrl_dp.sv | 110 +++++++++++
 tb/tb_fifo_ctrl_dp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs.sv
// Shared defaults for the byte-stream FIFO controller and its 64x8 dual-port RAM.
//   DW_DEF       : data width (must match the RAM word width)
//   AW_DEF       : address width; depth is 2**AW_DEF
//   AF_LEVEL_DEF : occupancy at or above which almost_full asserts
//   DEPTH        : number of entries for the default address width
//   fifo_depth() : number of entries for a given address width
package fifo_defs;

  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned AW_DEF       = 6;
  localparam int unsigned AF_LEVEL_DEF = 56;
  localparam int unsigned DEPTH        = 1 << AW_DEF;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer with enable. Wraps naturally from 2**AW-1 to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, pointer returns to 0
//   en    : advance the pointer by one this cycle
//   ptr   : current pointer value
module fifo_ptr
  import fifo_defs::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl_dp.sv
// Synchronous FIFO controller sitting directly upstream of a true dual-port RAM.
// RAM port 1 is the write port, RAM port 2 is read-only. The RAM's registered
// q2 is passed straight through as rd_data and qualified by rd_valid.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en, wr_data      : push request and data
//   rd_en               : pop request
//   rd_data, rd_valid   : pop data (from ram_q2) and its strobe, one cycle after the pop
//   full, empty         : registered occupancy flags
//   almost_full         : registered, count >= AF_LEVEL
//   count               : registered occupancy 0..2**AW
//   overflow, underflow : one-cycle pulses for a rejected push / pop
//   ram_we1/add1/d1     : RAM write port
//   ram_we2/add2/d2     : RAM read port (write side tied off)
//   ram_q2              : RAM registered read data
module fifo_ctrl_dp
  import fifo_defs::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned AF_LEVEL = AF_LEVEL_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic          ram_we1,
  output logic [AW-1:0] ram_add1,
  output logic [DW-1:0] ram_d1,
  output logic          ram_we2,
  output logic [AW-1:0] ram_add2,
  output logic [DW-1:0] ram_d2,
  input  logic [DW-1:0] ram_q2
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(fifo_depth(AW));
  localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);

  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;

  // Acceptance uses the registered flags, so at full a simultaneous push is
  // refused while the pop proceeds, and at empty the reverse.
  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop_ok),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  // Flags are derived from count_nxt so they are registered alongside count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_CNT);
      almost_full <= (count_nxt >= AF_CNT);
      rd_valid    <= pop_ok;
      overflow    <= wr_en & full;
      underflow   <= rd_en & empty;
    end
  end

  assign ram_we1  = push_ok;
  assign ram_add1 = wr_ptr;
  assign ram_d1   = wr_data;
  assign ram_we2  = 1'b0;
  assign ram_add2 = rd_ptr;
  assign ram_d2   = '0;
  assign rd_data  = ram_q2;

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
module tb_fifo_ctrl_dp;
  import fifo_defs::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
  logic       ram_we1;
  logic [5:0] ram_add1;
  logic [7:0] ram_d1;
  logic       ram_we2;
  logic [5:0] ram_add2;
  logic [7:0] ram_d2;
  logic [7:0] ram_q2;

  always #5 clk = ~clk;

  fifo_ctrl_dp #(.DW(8), .AW(6), .AF_LEVEL(56)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_we1     (ram_we1),
    .ram_add1    (ram_add1),
    .ram_d1      (ram_d1),
    .ram_we2     (ram_we2),
    .ram_add2    (ram_add2),
    .ram_d2      (ram_d2),
    .ram_q2      (ram_q2)
  );

  // Behavioural 64x8 RAM: port 1 writes, port 2 registered read.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we1) mem[ram_add1] <= ram_d1;
    ram_q2 <= mem[ram_add2];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] q[$];       // FIFO contents
  logic [7:0] exp_rd[$];  // scoreboard of data expected on rd_data
  int m_wp = 0;
  int m_rp = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd.delete();
    m_wp = 0;
    m_rp = 0;
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit re);
    bit push_ok, pop_ok, ovf, unf;
    int cnt;
    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re;
    cnt     = q.size();
    push_ok = we && (cnt < int'(DEPTH));
    pop_ok  = re && (cnt > 0);
    ovf     = we && (cnt == int'(DEPTH));
    unf     = re && (cnt == 0);
    #1;
    chk("ram_we1", int'(ram_we1), int'(push_ok));
    chk("ram_add1", int'(ram_add1), m_wp);
    chk("ram_add2", int'(ram_add2), m_rp);
    if (push_ok) chk("ram_d1", int'(ram_d1), int'(wd));
    if (pop_ok) begin
      exp_rd.push_back(q.pop_front());
      m_rp = (m_rp + 1) % 64;
    end
    if (push_ok) begin
      q.push_back(wd);
      m_wp = (m_wp + 1) % 64;
    end
    cnt = q.size();
    @(posedge clk);
    #1;
    chk("count", int'(count), cnt);
    chk("empty", int'(empty), int'(cnt == 0));
    chk("full", int'(full), int'(cnt == int'(DEPTH)));
    chk("almost_full", int'(almost_full), int'(cnt >= int'(AF_LEVEL_DEF)));
    chk("overflow", int'(overflow), int'(ovf));
    chk("underflow", int'(underflow), int'(unf));
    chk("rd_valid", int'(rd_valid), int'(pop_ok));
    if (pop_ok && exp_rd.size() > 0) chk("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
  endtask

  typedef struct {
    bit         we;
    logic [7:0] wd;
    bit         re;
    int         exp_count;
    bit         exp_ovf;
    bit         exp_unf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Starting from empty: simultaneous push/pop at empty, pops of the result,
    // pop at empty, mixed traffic.
    vecs[0] = '{1'b1, 8'h5C, 1'b1, 1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h33, 1'b1, 2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_ram_we1", int'(ram_we1), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);
    chk("ram_we2", int'(ram_we2), 0);
    chk("ram_d2", int'(ram_d2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].exp_unf));
    end

    // Fill 0x00..0x3F
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 54) chk("af_below", int'(almost_full), 0);
      if (i == 55) chk("af_at_56", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 64);

    // Overflow: push 0xAA while full
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 64);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_one_cycle", int'(overflow), 0);

    // Push+pop while full: pop wins, count 63
    step(1'b1, 8'hAA, 1'b1);
    chk("full_pp_count", int'(count), 63);
    chk("full_pp_ovf", int'(overflow), 1);

    // Drain the rest; scoreboard checks order and absence of 0xAA
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", int'(empty), 1);
    step(1'b0, 8'h00, 1'b0);

    // Wrap with count held at 10
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      if (count != 7'd10) chk("wrap_count", int'(count), 10);
    end
    chk("wrap_count_end", int'(count), 10);

    // Reset mid-stream with a pop in flight
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    chk("pre_rst_count", int'(count), 20);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1;
    @(posedge clk);
    #1;
    chk("inflight_valid", int'(rd_valid), 1);
    #1;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_empty", int'(empty), 1);
    chk("post_rst_count", int'(count), 0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
